// File: rtl/debounce_pkg.sv
// Shared constants, per-channel event bundle and a cycle-count helper for the
// push-button debouncer array.
package debounce_pkg;

    localparam int unsigned CLK_HZ_DEFAULT     = 32'd50_000_000;
    localparam int unsigned CNT_MAX_DEFAULT    = 32'd1_000_000;
    localparam int unsigned LONG_MAX_DEFAULT   = 32'd50_000_000;
    localparam int unsigned REPEAT_MAX_DEFAULT = 32'd10_000_000;

    typedef struct packed {
        logic level;
        logic press;
        logic rel;
        logic lng;
        logic rpt;
    } btn_evt_t;

    // Divide first so a 1 s window at 50 MHz stays inside 32 bits.
    function automatic int unsigned ms_to_cycles(input int unsigned ms,
                                                 input int unsigned clk_hz);
        return (clk_hz / 32'd1000) * ms;
    endfunction

endpackage

// File: rtl/debounce_button_array_channel.sv
// One button channel: two-flop synchroniser, debounce window, edge pulses and
// the hold / auto-repeat timers.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned CNT_MAX    = CNT_MAX_DEFAULT,
    parameter int unsigned ACTIVE_LOW = 32'd1,
    parameter int unsigned LONG_MAX   = LONG_MAX_DEFAULT,
    parameter int unsigned REPEAT_EN  = 32'd1,
    parameter int unsigned REPEAT_MAX = REPEAT_MAX_DEFAULT
) (
    input  logic     clk_i,
    input  logic     reset_i,
    input  logic     btn_raw_i,
    output btn_evt_t evt_o,
    output logic     press_d_o
);

    localparam int unsigned CNT_W  = $clog2(CNT_MAX + 32'd1);
    localparam int unsigned HOLD_W = $clog2(LONG_MAX + 32'd1);
    localparam int unsigned REP_W  = $clog2(REPEAT_MAX + 32'd1);

    localparam logic              INACTIVE = (ACTIVE_LOW != 32'd0) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0]  CNT_TOP  = CNT_W'(CNT_MAX);
    localparam logic [HOLD_W-1:0] HOLD_TOP = HOLD_W'(LONG_MAX);
    localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_MAX - 32'd1);
    localparam logic [REP_W-1:0]  REP_PRE  = REP_W'(REPEAT_MAX - 32'd1);

    logic              sync0_q, sync1_q;
    logic              stable_q, stable_d;
    logic              prev_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [REP_W-1:0]  rep_q, rep_d;
    logic              press_q, press_d;
    logic              rel_q, rel_d;
    logic              long_q, long_d;
    logic              rpt_q, rpt_d;
    logic              pressed_s;

    // Debounce window, edge detection and hold/repeat next-state.
    always_comb begin
        pressed_s = sync1_q ^ INACTIVE;
        stable_d  = stable_q;
        cnt_d     = '0;
        hold_d    = hold_q;
        rep_d     = rep_q;
        press_d   = stable_q & ~prev_q;
        rel_d     = ~stable_q & prev_q;
        long_d    = 1'b0;
        rpt_d     = 1'b0;

        if (pressed_s != stable_q) begin
            if (cnt_q == CNT_TOP) begin
                stable_d = pressed_s;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
        end

        // Decisions use the pre-edge level, so a release landing on the
        // long-press edge still lets that long pulse out.
        if (!stable_q) begin
            hold_d = '0;
            rep_d  = '0;
        end else if (press_d) begin
            hold_d = '0;
            rep_d  = '0;
        end else if (hold_q != HOLD_TOP) begin
            hold_d = hold_q + HOLD_W'(1);
            long_d = (hold_q == HOLD_PRE);
        end else if (REPEAT_EN != 32'd0) begin
            if (rep_q == REP_PRE) begin
                rep_d = '0;
                rpt_d = 1'b1;
            end else begin
                rep_d = rep_q + REP_W'(1);
            end
        end else begin
            rep_d = '0;
        end
    end

    // Channel state and registered outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync0_q  <= INACTIVE;
            sync1_q  <= INACTIVE;
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
            cnt_q    <= '0;
            hold_q   <= '0;
            rep_q    <= '0;
            press_q  <= 1'b0;
            rel_q    <= 1'b0;
            long_q   <= 1'b0;
            rpt_q    <= 1'b0;
        end else begin
            sync0_q  <= btn_raw_i;
            sync1_q  <= sync0_q;
            stable_q <= stable_d;
            prev_q   <= stable_q;
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
            rep_q    <= rep_d;
            press_q  <= press_d;
            rel_q    <= rel_d;
            long_q   <= long_d;
            rpt_q    <= rpt_d;
        end
    end

    assign evt_o = '{level: stable_q, press: press_q, rel: rel_q, lng: long_q, rpt: rpt_q};
    assign press_d_o = press_d;

endmodule

// File: rtl/debounce_button_array.sv
// N independent debounced button channels plus a registered any-press flag
// aligned with the per-channel press pulses.
module debounce_button_array
    import debounce_pkg::*;
#(
    parameter int unsigned N_BTN      = 32'd4,
    parameter int unsigned CNT_MAX    = CNT_MAX_DEFAULT,
    parameter int unsigned ACTIVE_LOW = 32'd1,
    parameter int unsigned LONG_MAX   = LONG_MAX_DEFAULT,
    parameter int unsigned REPEAT_EN  = 32'd1,
    parameter int unsigned REPEAT_MAX = REPEAT_MAX_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] long_pulse,
    output logic [N_BTN-1:0] repeat_pulse,
    output logic             any_press
);

    btn_evt_t         evt_s [N_BTN];
    logic [N_BTN-1:0] press_next_s;
    logic             any_press_q;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        debounce_channel #(
            .CNT_MAX    (CNT_MAX),
            .ACTIVE_LOW (ACTIVE_LOW),
            .LONG_MAX   (LONG_MAX),
            .REPEAT_EN  (REPEAT_EN),
            .REPEAT_MAX (REPEAT_MAX)
        ) u_ch (
            .clk_i     (clk),
            .reset_i   (reset),
            .btn_raw_i (btn_raw[i]),
            .evt_o     (evt_s[i]),
            .press_d_o (press_next_s[i])
        );

        assign btn_level[i]     = evt_s[i].level;
        assign press_pulse[i]   = evt_s[i].press;
        assign release_pulse[i] = evt_s[i].rel;
        assign long_pulse[i]    = evt_s[i].lng;
        assign repeat_pulse[i]  = evt_s[i].rpt;
    end

    // OR of the channels' next press values, so the flag lines up with press_pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            any_press_q <= 1'b0;
        end else begin
            any_press_q <= |press_next_s;
        end
    end

    assign any_press = any_press_q;

endmodule

// File: tb/tb_debounce_button_array.sv
// Directed + randomized bench for debounce_button_array (2 channels, short
// windows) against a window-based reference model of the button behaviour.
module tb_debounce_button_array;

    localparam int CNT  = 4;
    localparam int LONG = 10;
    localparam int RM   = 5;
    localparam int MAXE = 4000;

    logic       clk;
    logic       reset;
    logic [1:0] btn_raw;
    logic [1:0] lvl_a, prs_a, rel_a, lng_a, rpt_a;
    logic [1:0] lvl_b, prs_b, rel_b, lng_b, rpt_b;
    logic       any_a, any_b;

    debounce_button_array #(
        .N_BTN(32'd2), .CNT_MAX(32'd4), .ACTIVE_LOW(32'd1),
        .LONG_MAX(32'd10), .REPEAT_EN(32'd1), .REPEAT_MAX(32'd5)
    ) u_dut (
        .clk(clk), .reset(reset), .btn_raw(btn_raw),
        .btn_level(lvl_a), .press_pulse(prs_a), .release_pulse(rel_a),
        .long_pulse(lng_a), .repeat_pulse(rpt_a), .any_press(any_a)
    );

    debounce_button_array #(
        .N_BTN(32'd2), .CNT_MAX(32'd4), .ACTIVE_LOW(32'd1),
        .LONG_MAX(32'd10), .REPEAT_EN(32'd0), .REPEAT_MAX(32'd5)
    ) u_dut_nr (
        .clk(clk), .reset(reset), .btn_raw(btn_raw),
        .btn_level(lvl_b), .press_pulse(prs_b), .release_pulse(rel_b),
        .long_pulse(lng_b), .repeat_pulse(rpt_b), .any_press(any_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-edge history: raw value seen by edge e, reset at edge e, level after edge e.
    logic [1:0] raw_h  [MAXE];
    bit         rst_h  [MAXE];
    bit   [1:0] stab_h [MAXE];
    int e        = -1;
    int last_rst = 0;
    int checks   = 0;
    int errors   = 0;
    logic [1:0] x_lvl, x_prs, x_rel, x_lng, x_rpt;

    // Pressed value seen by the debouncer at edge k (two-flop delay, reset forces idle).
    function automatic bit pressed_at(input int k, input int c);
        if (k <= last_rst + 2) return 1'b0;
        return ~raw_h[k-2][c];
    endfunction

    task automatic model_edge();
        bit cur, flip, prevv;
        int r, d;
        x_lvl = 2'b00; x_prs = 2'b00; x_rel = 2'b00; x_lng = 2'b00; x_rpt = 2'b00;
        if (rst_h[e]) begin
            last_rst  = e;
            stab_h[e] = 2'b00;
            return;
        end
        for (int c = 0; c < 2; c++) begin
            cur  = stab_h[e-1][c];
            flip = 1'b1;
            // Level flips only after CNT+1 consecutive disagreeing samples since reset.
            for (int j = 0; j <= CNT; j++) begin
                if ((e - j) <= last_rst || pressed_at(e - j, c) == cur) flip = 1'b0;
            end
            stab_h[e][c] = flip ? ~cur : cur;
            x_lvl[c] = stab_h[e][c];
            prevv = rst_h[e-1] ? 1'b0 : stab_h[e-2][c];
            x_prs[c] = cur & ~prevv;
            x_rel[c] = ~cur & prevv;
            if (cur) begin
                r = e - 1;
                while ((r - 1) > last_rst && stab_h[r-1][c]) r--;
                d = e - (r + 1);
                x_lng[c] = (d == LONG);
                x_rpt[c] = (d > LONG) && (((d - LONG) % RM) == 0);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b edge=%0d", tag, obs, exp, e);
        end
    endtask

    task automatic step(input logic [1:0] raw, input bit rst);
        btn_raw = raw;
        reset   = rst;
        @(posedge clk);
        e++;
        if (e >= MAXE) begin
            $display("FAIL edge_budget observed=%0d required<%0d", e, MAXE);
            $fatal(1);
        end
        raw_h[e] = raw;
        rst_h[e] = rst;
        model_edge();
        #1;
        chk("level",      lvl_a, x_lvl);
        chk("press",      prs_a, x_prs);
        chk("release",    rel_a, x_rel);
        chk("long",       lng_a, x_lng);
        chk("repeat",     rpt_a, x_rpt);
        chk("any_press",  {1'b0, any_a}, {1'b0, |x_prs});
        chk("nr_level",   lvl_b, x_lvl);
        chk("nr_press",   prs_b, x_prs);
        chk("nr_release", rel_b, x_rel);
        chk("nr_long",    lng_b, x_lng);
        chk("nr_repeat",  rpt_b, 2'b00);
        chk("nr_any",     {1'b0, any_b}, {1'b0, |x_prs});
    endtask

    task automatic run(input logic [1:0] raw, input bit rst, input int n);
        for (int i = 0; i < n; i++) step(raw, rst);
    endtask

    logic [1:0] v;
    int         n;
    bit         bnc, rs;

    initial begin
        btn_raw = 2'b11;
        reset   = 1'b1;
        run(2'b11, 1'b1, 2);
        run(2'b11, 1'b0, 4);
        // Clean press on channel 0, channel 1 idle.
        run(2'b10, 1'b0, 30);
        run(2'b11, 1'b0, 20);
        // Bouncing contact then a solid press.
        for (int i = 0; i < 8; i++) step((i % 2 == 0) ? 2'b10 : 2'b11, 1'b0);
        run(2'b10, 1'b0, 20);
        run(2'b11, 1'b0, 20);
        // Long hold with auto-repeat.
        run(2'b10, 1'b0, 40);
        run(2'b11, 1'b0, 20);
        // Short press: released before the long-press point.
        run(2'b10, 1'b0, 15);
        run(2'b11, 1'b0, 20);
        // Both channels pressed together.
        run(2'b00, 1'b0, 20);
        run(2'b11, 1'b0, 20);
        // Reset during debounce with the button still held.
        run(2'b10, 1'b0, 3);
        run(2'b10, 1'b1, 1);
        run(2'b10, 1'b0, 20);
        run(2'b11, 1'b0, 20);
        // Hold lengths around the long-press edge on channel 1.
        for (int h = 8; h <= 14; h++) begin
            run(2'b01, 1'b0, h);
            run(2'b11, 1'b0, 15);
        end
        // Random segments with occasional bounce and reset.
        for (int s = 0; s < 30; s++) begin
            v   = 2'($urandom_range(0, 3));
            n   = $urandom_range(1, 45);
            bnc = ($urandom_range(0, 9) == 0);
            rs  = ($urandom_range(0, 14) == 0);
            for (int i = 0; i < n; i++) begin
                step((bnc && i < 6 && (i % 2 == 1)) ? ~v : v, rs && (i == n / 2));
            end
        end
        run(2'b11, 1'b0, 30);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/debounce_button_array.md
Name: debounce_button_array

Overview:
- N-channel successor to the single-button debouncer. Synchronises, debounces and edge-detects up to N_BTN raw push-button or switch inputs with selectable polarity.
- Per channel it produces:
  - a clean level;
  - one-cycle press and release pulses;
  - a one-shot long-press pulse;
  - optional auto-repeat pulses while the button is held.
- Sits between board KEY/SW pins and controller FSMs, e.g. pedestrian request and manual override in the traffic-light controller.

Parameters:
- N_BTN, 4, number of independent channels (1..16).
- CNT_MAX, 1_000_000, debounce window in cycles (~20 ms at 50 MHz); counter width is $clog2(CNT_MAX+1).
- ACTIVE_LOW, 1, 1 = raw input reads 0 when pressed; 0 = reads 1 when pressed.
- LONG_MAX, 50_000_000, cycles a press must be held before long_pulse (~1 s).
- REPEAT_EN, 1, 1 = emit repeat_pulse while held past LONG_MAX; 0 = repeat_pulse tied low.
- REPEAT_MAX, 10_000_000, auto-repeat period in cycles (~200 ms).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- btn_raw  in  N_BTN  asynchronous raw button pins.
- btn_level  out  N_BTN  debounced level, 1 = pressed.
- press_pulse  out  N_BTN  1-cycle pulse on debounced 0->1.
- release_pulse  out  N_BTN  1-cycle pulse on debounced 1->0.
- long_pulse  out  N_BTN  1-cycle pulse when a hold reaches LONG_MAX.
- repeat_pulse  out  N_BTN  1-cycle pulse every REPEAT_MAX cycles after long_pulse while held.
- any_press  out  1  OR of press_pulse (registered copy, same cycle as press_pulse).

Behaviour:
- Reset (synchronous, active-high):
  - sync flops load the inactive level (ACTIVE_LOW ? 1 : 0);
  - stable level, counters and all outputs are cleared to 0.
- After reset:
  - a button still held is a genuine press and produces press_pulse after the normal latency.
  - reset asserted mid-debounce or mid-hold discards the in-progress count; no pulse is emitted.
- Synchroniser: 2 flops per channel. pressed = sync1 XOR ACTIVE_LOW.
- Debounce, per channel:
  - if pressed != stable: at cnt == CNT_MAX, stable <= pressed and cnt <= 0; otherwise cnt++.
  - if pressed == stable: cnt <= 0. Any glitch restarts the window.
  - the input must disagree with stable for CNT_MAX+1 consecutive sampled cycles.
- Latency:
  - raw edge set up before clock edge 0: stable changes at edge CNT_MAX+2.
  - press_pulse / release_pulse are registered and high in the cycle after edge CNT_MAX+3, for exactly 1 cycle.
  - btn_level = stable (registered).
- Hold counter:
  - hold_cnt clears on the press edge and increments every cycle while stable = 1.
  - long_pulse fires when hold_cnt hits LONG_MAX, i.e. exactly LONG_MAX cycles after press_pulse. Once per press.
  - then, if REPEAT_EN, rep_cnt runs and repeat_pulse fires every REPEAT_MAX cycles: first at LONG_MAX+REPEAT_MAX cycles after press_pulse.
  - hold_cnt saturates at LONG_MAX (no wrap); rep_cnt wraps to 0 at each repeat.
- Release clears hold_cnt and rep_cnt. No long/repeat pulse in the release cycle or after it.
  - release exactly on the long_pulse cycle: long_pulse still fires (already decided by the prior edge); no repeats follow.
- Press and release can never coincide on one channel.
- Channels are fully independent; simultaneous events on different channels each produce their own pulses in the same cycle.
- any_press is high if one or more channels pulse.
- Per-channel state: 2 sync + stable + prev + debounce cnt + hold cnt + repeat cnt. No cross-channel sharing.

Decomposition:
- Shared package debounce_pkg:
  - default constants for CNT_MAX / LONG_MAX / REPEAT_MAX at 50 MHz;
  - a function returning a cycle count from milliseconds and clock frequency.
- One sub-module, debounce_channel (synchroniser, debounce, edge, hold/repeat logic for one input). The top instantiates it N_BTN times via generate and ORs press pulses for any_press.

Test Plan:
(All scenarios use N_BTN=2, CNT_MAX=4, LONG_MAX=10, REPEAT_MAX=5, ACTIVE_LOW=1.)
- Clean press: btn_raw[0] 1->0 before edge 0 and held -> btn_level[0]=1 at edge 6; press_pulse[0] high 1 cycle after edge 7; any_press same cycle; btn_raw[1] channel stays 0.
- Bounce: btn_raw[0] toggles 0,1,0,1 on alternate cycles for 8 cycles, then held 0 -> no pulse during the bounce; exactly one press_pulse, 7 edges after the last transition.
- Long + repeat: hold 40 cycles -> long_pulse 10 cycles after press_pulse; repeat_pulse at +15, +20, +25...; release -> release_pulse after CNT_MAX+3 edges; no further repeats.
- Short press: hold 8 cycles past press_pulse, then release -> no long_pulse, one release_pulse. REPEAT_EN=0 run: long_pulse only, repeat_pulse never high.
- Simultaneous channels: both channels pressed on the same edge -> press_pulse=2'b11 in one cycle, any_press=1 for 1 cycle.
- Reset mid-operation: assert reset for 1 cycle during debounce counting -> all outputs 0, no pulse. Button still held -> press_pulse 7 edges after reset deassertion.
